// File: rtl/bnn_dense_seq.sv
// rtl/bnn_dense_seq.sv - sequential binary dense layer with XNOR-popcount scoring and arg-max
//
// Purpose: scores a binary feature vector against NUM_NEURONS binary weight rows,
// one CHUNK-bit slice of one neuron per clock, then thresholds each score and
// reports the index of the highest score (lowest index wins ties).
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid       in_feature is valid
//   in_ready       idle, a vector can be accepted
//   in_feature     IN_BITS feature vector (captured on accept)
//   weights        NUM_NEURONS rows of IN_BITS, row n at [n*IN_BITS +: IN_BITS]
//   thresholds     NUM_NEURONS unsigned SW-bit thresholds, n at [n*SW +: SW]
//   out_valid      results valid (held until out_ready)
//   out_ready      downstream accepts results
//   out_bits       bit n = score[n] >= threshold[n]
//   out_scores     score n at [n*SW +: SW]
//   out_class      index of the maximum score
module bnn_dense_seq #(
  parameter int  IN_BITS     = 588,
  parameter int  CHUNK       = 84,
  parameter int  NUM_NEURONS = 10,
  localparam int NUM_CHUNKS  = IN_BITS / CHUNK,
  localparam int SW          = $clog2(IN_BITS + 1),
  localparam int IW          = $clog2(NUM_NEURONS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_BITS-1:0]          in_feature,
  input  logic [NUM_NEURONS*IN_BITS-1:0] weights,
  input  logic [NUM_NEURONS*SW-1:0]   thresholds,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_NEURONS-1:0]      out_bits,
  output logic [NUM_NEURONS*SW-1:0]   out_scores,
  output logic [IW-1:0]               out_class
);

  localparam int PCW = $clog2(CHUNK + 1);
  localparam int KW  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [IN_BITS-1:0] feat_q;
  logic [IW-1:0]      n;
  logic [KW-1:0]      k;
  logic [SW-1:0]      acc;
  logic [SW-1:0]      best;

  logic [CHUNK-1:0]   feat_chunk;
  logic [CHUNK-1:0]   w_chunk;
  logic [CHUNK-1:0]   match;
  logic [PCW-1:0]     pc;
  logic [SW-1:0]      sum;
  logic [SW-1:0]      thr;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Current slice: XNOR of feature and weight bits, then popcount.
  always_comb begin
    feat_chunk = feat_q[int'(k)*CHUNK +: CHUNK];
    w_chunk    = weights[int'(n)*IN_BITS + int'(k)*CHUNK +: CHUNK];
    match      = ~(feat_chunk ^ w_chunk);
    pc         = '0;
    for (int i = 0; i < CHUNK; i++) begin
      pc = pc + PCW'(match[i]);
    end
    sum = acc + SW'(pc);
    thr = thresholds[int'(n)*SW +: SW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      feat_q     <= '0;
      n          <= '0;
      k          <= '0;
      acc        <= '0;
      best       <= '0;
      out_bits   <= '0;
      out_scores <= '0;
      out_class  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            feat_q     <= in_feature;
            n          <= '0;
            k          <= '0;
            acc        <= '0;
            best       <= '0;
            out_bits   <= '0;
            out_scores <= '0;
            out_class  <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (k != KW'(NUM_CHUNKS - 1)) begin
            acc <= sum;
            k   <= k + 1'b1;
          end else begin
            out_scores[int'(n)*SW +: SW] <= sum;
            out_bits[n]                  <= (sum >= thr);
            // Strict compare keeps the earlier (lower) index on ties.
            if (n == '0 || sum > best) begin
              best      <= sum;
              out_class <= n;
            end
            acc <= '0;
            k   <= '0;
            if (n == IW'(NUM_NEURONS - 1)) begin
              state <= DONE;
            end else begin
              n <= n + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_dense_seq.sv
// tb/tb_bnn_dense_seq.sv - scoreboard testbench for bnn_dense_seq
module tb_bnn_dense_seq;
  localparam int IN_BITS = 588;
  localparam int CHUNK   = 84;
  localparam int NN      = 10;
  localparam int NC      = 7;
  localparam int SW      = 10;
  localparam int IW      = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_BITS-1:0]      in_feature;
  logic [NN*IN_BITS-1:0]   weights;
  logic [NN*SW-1:0]        thresholds;
  logic                    out_valid;
  logic                    out_ready;
  logic [NN-1:0]           out_bits;
  logic [NN*SW-1:0]        out_scores;
  logic [IW-1:0]           out_class;

  bnn_dense_seq #(.IN_BITS(IN_BITS), .CHUNK(CHUNK), .NUM_NEURONS(NN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_feature(in_feature),
    .weights(weights), .thresholds(thresholds),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bits(out_bits), .out_scores(out_scores), .out_class(out_class)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NN-1:0]    bits;
    logic [NN*SW-1:0] scores;
    logic [IW-1:0]    cls;
    int               acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   exp_sc[NN];
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [NN*SW-1:0] pack_scores();
    logic [NN*SW-1:0] s;
    s = '0;
    for (int i = 0; i < NN; i++) s[i*SW +: SW] = exp_sc[i][SW-1:0];
    return s;
  endfunction

  // Monitor: compares each new result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && !prev_v) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_out_valid");
      end else begin
        cur = sb.pop_front();
        check("out_bits", 128'(out_bits), 128'(cur.bits));
        check("out_scores", 128'(out_scores), 128'(cur.scores));
        check("out_class", 128'(out_class), 128'(cur.cls));
        check("latency", 128'(cyc - cur.acc_cyc), 128'(NC*NN));
      end
    end
    prev_v = out_valid;
  end

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) fail_now("timeout_in_ready");
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || !in_ready) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || !in_ready) fail_now("timeout_result");
  endtask

  task automatic send(input logic [IN_BITS-1:0] f, input logic [NN-1:0] b,
                      input logic [IW-1:0] c, input bit push);
    exp_t e;
    wait_ready();
    in_feature = f;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_feature = ~f;
    if (push) begin
      e.bits    = b;
      e.scores  = pack_scores();
      e.cls     = c;
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic set_thr_all(input int v);
    for (int i = 0; i < NN; i++) thresholds[i*SW +: SW] = SW'(v);
  endtask

  task automatic clear_sc();
    for (int i = 0; i < NN; i++) exp_sc[i] = 0;
  endtask

  task automatic setup_argmax();
    weights = '1;
    weights[3*IN_BITS +: IN_BITS] = '0;
    for (int j = 0; j < 100; j++) weights[7*IN_BITS + j] = 1'b0;
    set_thr_all(100);
    clear_sc();
    exp_sc[3] = 588;
    exp_sc[7] = 100;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NN*SW-1:0] bp_scores;
    int t;
    in_valid = 1'b0;
    in_feature = '0;
    weights = '0;
    thresholds = '0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_out_bits", 128'(out_bits), 128'(0));
    check("reset_out_scores", 128'(out_scores), 128'(0));
    check("reset_out_class", 128'(out_class), 128'(0));

    // All ones everywhere: every score is 588, tie resolves to neuron 0.
    weights = '1;
    set_thr_all(588);
    for (int i = 0; i < NN; i++) exp_sc[i] = 588;
    send('1, 10'h3FF, 4'd0, 1'b1);
    wait_drain();

    // Arg-max picks neuron 3; threshold 100 passes only neurons 3 and 7.
    setup_argmax();
    send('0, 10'h088, 4'd3, 1'b1);
    wait_drain();

    // Row 0 has set bits on both sides of the first chunk boundary.
    weights = '1;
    weights[0 +: IN_BITS] = '0;
    weights[83] = 1'b1;
    weights[84] = 1'b1;
    set_thr_all(0);
    clear_sc();
    exp_sc[0] = 586;
    send('0, 10'h3FF, 4'd0, 1'b1);
    wait_drain();

    // Single set bit in the last position of the last chunk.
    weights[0 +: IN_BITS] = '0;
    weights[587] = 1'b1;
    set_thr_all(589);
    thresholds[0 +: SW] = 10'd588;
    clear_sc();
    exp_sc[0] = 587;
    send('0, 10'h000, 4'd0, 1'b1);
    wait_drain();

    // Threshold edges on score 300: equal, one above, zero.
    weights = '1;
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 300; j++) weights[r*IN_BITS + j] = 1'b0;
    set_thr_all(0);
    thresholds[0*SW +: SW] = 10'd300;
    thresholds[1*SW +: SW] = 10'd301;
    clear_sc();
    exp_sc[0] = 300;
    exp_sc[1] = 300;
    exp_sc[2] = 300;
    send('0, 10'h3FD, 4'd0, 1'b1);
    wait_drain();

    // Backpressure in DONE while in_valid/in_feature wiggle.
    weights = '1;
    for (int j = 0; j < 200; j++) weights[5*IN_BITS + j] = 1'b0;
    set_thr_all(1);
    clear_sc();
    exp_sc[5] = 200;
    bp_scores = pack_scores();
    out_ready = 1'b0;
    send('0, 10'h020, 4'd5, 1'b1);
    t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) fail_now("timeout_bp_out_valid");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i % 2 == 0);
      for (int j = 0; j < IN_BITS; j++) in_feature[j] = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_out_bits", 128'(out_bits), 128'(10'h020));
      check("bp_out_scores", 128'(out_scores), 128'(bp_scores));
      check("bp_out_class", 128'(out_class), 128'(5));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", 128'(in_ready), 128'(1));
    check("bp_release_out_valid", 128'(out_valid), 128'(0));
    check("bp_hold_out_class", 128'(out_class), 128'(5));

    // Second vector after backpressure.
    weights = '1;
    set_thr_all(588);
    for (int i = 0; i < NN; i++) exp_sc[i] = 588;
    send('1, 10'h3FF, 4'd0, 1'b1);
    wait_drain();

    // Reset 30 cycles into RUN discards the vector.
    setup_argmax();
    send('0, '0, '0, 1'b0);
    repeat (29) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_out_bits", 128'(out_bits), 128'(0));
    check("midrst_out_scores", 128'(out_scores), 128'(0));
    check("midrst_out_class", 128'(out_class), 128'(0));
    send('0, 10'h088, 4'd3, 1'b1);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bnn_dense_seq.md
Name: bnn_dense_seq

Overview:
- Sequential binary fully-connected (dense) layer. Sits directly downstream of the binary max-pool stage and consumes its flattened multi-channel feature vector.
- For each output neuron it computes an XNOR-popcount score against a binary weight row, thresholds it, and tracks the arg-max neuron as the class result.
- Work is time-multiplexed: one CHUNK-bit slice of one neuron is processed per clock.

Parameters:
- IN_BITS, 588, input vector width; equals the pool output width (3 ch x 14 x 14).
- CHUNK, 84, bits processed per cycle; IN_BITS must be an integer multiple of CHUNK.
- NUM_NEURONS, 10, number of output neurons.
- NUM_CHUNKS, IN_BITS/CHUNK (7), derived.
- SW, $clog2(IN_BITS+1) (10), score width, derived.
- IW, $clog2(NUM_NEURONS) (4), class index width, derived.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_feature is valid.
- in_ready  output  1  block is idle and can accept a vector.
- in_feature  input  IN_BITS  pooled feature vector; bit i is pool output index i.
- weights  input  NUM_NEURONS*IN_BITS  neuron n row at [n*IN_BITS +: IN_BITS]; must be static while busy.
- thresholds  input  NUM_NEURONS*SW  neuron n threshold at [n*SW +: SW], unsigned; must be static while busy.
- out_valid  output  1  results are valid.
- out_ready  input  1  downstream accepts the results.
- out_bits  output  NUM_NEURONS  bit n = (score[n] >= threshold[n]).
- out_scores  output  NUM_NEURONS*SW  score n at [n*SW +: SW].
- out_class  output  IW  index of the maximum score.

Behaviour:
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
  - in_ready and out_valid are decoded directly from the state register.
- Reset (asynchronous, any state):
  - State goes to IDLE; neuron counter n, chunk counter k and accumulator acc clear to 0.
  - out_bits, out_scores and out_class clear to 0; the internal best score clears to 0.
  - A reset during RUN or DONE discards all work. in_ready=1 from the first cycle after reset deasserts.
- IDLE, on the edge where in_valid && in_ready:
  - Register in_feature into feat_q; set n=0, k=0, acc=0; go to RUN.
  - Clear out_bits, out_scores, out_class and the best score.
- RUN, each cycle:
  - pc = popcount(~(feat_q[k*CHUNK +: CHUNK] ^ W[n][k*CHUNK +: CHUNK])), width $clog2(CHUNK+1).
  - sum = acc + pc, zero-extended to SW bits. sum never overflows because its maximum is IN_BITS.
  - If k < NUM_CHUNKS-1: acc <= sum, k <= k+1.
  - If k == NUM_CHUNKS-1:
    - out_scores[n] <= sum.
    - out_bits[n] <= (sum >= threshold[n]).
    - If n==0 or sum > best: best <= sum, out_class <= n. Ties keep the lower index.
    - acc <= 0, k <= 0.
    - If n == NUM_NEURONS-1 go to DONE, else n <= n+1.
- Latency:
  - out_valid rises exactly NUM_NEURONS*NUM_CHUNKS cycles (70 with defaults) after the accept edge.
  - Throughput is one vector per 70 + 1 (DONE) + 1 (IDLE) cycles minimum.
- DONE:
  - All outputs are held stable while out_ready=0; in_valid is ignored.
  - On the edge where out_ready=1, go to IDLE. Outputs keep their values until the next accept.
- in_valid while in RUN or DONE is not accepted. The upstream stage must hold it.
- Changes to in_feature after the accept edge have no effect, because feat_q is captured.
- A threshold of 0 forces the bit to 1. A threshold greater than IN_BITS forces the bit to 0.

Test Plan:
- Latency and ordering: in_feature all 1s, weights all 1s, thresholds all 588, accept at cycle T.
  - out_valid at T+70; all scores 588; out_bits=10'h3FF; out_class=0 (tie rule).
- Arg-max: in_feature all 0s; weight rows all 1s except row 3 all 0s and row 7 with 100 zero bits.
  - Scores 0 except n3=588 and n7=100; out_class=3.
  - With thresholds=100: out_bits has only bits 3 and 7 set.
- Chunk boundary: in_feature all 0s; row 0 all 0s except bits 83 and 84 set, other rows all 1s.
  - score[0]=586, other scores 0, out_class=0.
  - Repeat with a single set bit at 587: score[0]=587.
- Threshold edge: score 300 with threshold 300 -> bit 1; threshold 301 -> bit 0; threshold 0 -> bit 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and toggle in_valid/in_feature.
  - Outputs stay constant and in_ready=0.
  - out_ready=1 -> IDLE next cycle; a second vector is then accepted and processed correctly.
- Reset mid-RUN: assert rst_n=0 at cycle 30 of RUN.
  - All outputs 0 and in_ready=1 after release.
  - A fresh vector gives correct results 70 cycles after its accept edge.
